// File: rtl/ppu_vram_port.sv
// CPU-side PPU register port: $2000/$2002/$2006/$2007 address and data path
// into VRAM and palette RAM, with the buffered-read behaviour of $2007.
module ppu_vram_port (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_sel,
  input  logic        cpu_rw,
  input  logic [2:0]  cpu_reg,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_dout_valid,
  output logic        busy,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_wren,
  output logic        vram_rden,
  input  logic [7:0]  vram_rdata,
  output logic [4:0]  pal_addr,
  output logic [7:0]  pal_wdata,
  output logic        pal_wren,
  input  logic [7:0]  pal_rdata
);

  typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_CAP} state_t;

  state_t      state;
  logic [13:0] v;
  logic [5:0]  t_hi;
  logic        w;
  logic        inc32;
  logic [7:0]  rbuf;
  logic [7:0]  wdata;

  logic [13:0] v_inc;
  logic        v_pal, v_nt, v_rom;

  assign v_inc = v + (inc32 ? 14'd32 : 14'd1);
  assign v_pal = (v >= 14'h3F00);
  assign v_rom = (v < 14'h2000);
  assign v_nt  = !v_pal && !v_rom;

  assign busy       = (state != IDLE);
  assign pal_addr   = v[4:0];
  // Reads fold the $3xxx mirror back onto the nametable range
  assign vram_addr  = (state == RD_ISSUE) ? (v & 14'h2FFF) : v;
  assign vram_wdata = wdata;
  assign pal_wdata  = wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      v              <= '0;
      t_hi           <= '0;
      w              <= 1'b0;
      inc32          <= 1'b0;
      rbuf           <= '0;
      wdata          <= '0;
      cpu_dout       <= '0;
      cpu_dout_valid <= 1'b0;
      vram_wren      <= 1'b0;
      vram_rden      <= 1'b0;
      pal_wren       <= 1'b0;
    end else begin
      cpu_dout_valid <= 1'b0;
      vram_wren      <= 1'b0;
      vram_rden      <= 1'b0;
      pal_wren       <= 1'b0;
      case (state)
        IDLE: if (cpu_sel) begin
          if (cpu_rw) begin
            case (cpu_reg)
              3'd2: w <= 1'b0;
              3'd7: begin
                cpu_dout       <= v_pal ? pal_rdata : rbuf;
                cpu_dout_valid <= 1'b1;
                vram_rden      <= !v_rom;
                state          <= RD_ISSUE;
              end
              default: ;
            endcase
          end else begin
            case (cpu_reg)
              3'd0: inc32 <= cpu_din[2];
              3'd6: begin
                if (!w) begin
                  t_hi <= cpu_din[5:0];
                  w    <= 1'b1;
                end else begin
                  v <= {t_hi, cpu_din};
                  w <= 1'b0;
                end
              end
              3'd7: begin
                // strobes are registered so they line up with the WR cycle
                wdata     <= cpu_din;
                vram_wren <= v_nt;
                pal_wren  <= v_pal;
                state     <= WR;
              end
              default: ;
            endcase
          end
        end
        WR: begin
          v     <= v_inc;
          state <= IDLE;
        end
        RD_ISSUE: state <= RD_CAP;
        RD_CAP: begin
          rbuf  <= v_rom ? 8'h00 : vram_rdata;
          v     <= v_inc;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ppu_vram_port.md
PPU_VRAM_PORT -- requirements
Module: ppu_vram_port

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port cpu_sel, input, 1 bit: one-cycle strobe marking a CPU PPU-register access.
REQ-004 SHALL have port cpu_rw, input, 1 bit: 1 = read, 0 = write; sampled with cpu_sel.
REQ-005 SHALL have port cpu_reg, input, 3 bits: PPU register index; 0 = $2000, 2 = $2002, 6 = $2006, 7 = $2007.
REQ-006 SHALL have port cpu_din, input, 8 bits: CPU write data.
REQ-007 SHALL have port cpu_dout, output, 8 bits: $2007 read result, registered.
REQ-008 SHALL have port cpu_dout_valid, output, 1 bit: one-cycle pulse qualifying cpu_dout.
REQ-009 SHALL have port busy, output, 1 bit: a $2007 sequence is in progress.
REQ-010 SHALL have port vram_addr, output, 14 bits: VRAM address.
REQ-011 SHALL have port vram_wdata, output, 8 bits: VRAM write data.
REQ-012 SHALL have port vram_wren, output, 1 bit: VRAM write strobe.
REQ-013 SHALL have port vram_rden, output, 1 bit: VRAM read strobe.
REQ-014 SHALL have port vram_rdata, input, 8 bits: VRAM read data, valid one cycle after vram_rden.
REQ-015 SHALL have port pal_addr, output, 5 bits: palette index, combinationally equal to v[4:0].
REQ-016 SHALL have port pal_wdata, output, 8 bits: palette write data.
REQ-017 SHALL have port pal_wren, output, 1 bit: palette write strobe.
REQ-018 SHALL have port pal_rdata, input, 8 bits: palette data, combinational from pal_addr.

Function
REQ-019 SHALL hold internal state: v[13:0] (current address), t_hi[5:0] (high address byte), w (write toggle), inc32, rbuf[7:0] (read buffer), and FSM state.
REQ-020 SHALL have FSM states IDLE, WR, RD_ISSUE, RD_CAP; busy SHALL equal (state != IDLE).
REQ-021 SHALL accept cpu_sel only in IDLE; any cpu_sel while busy=1 SHALL be ignored with no state change.
REQ-022 SHALL, on a write to reg 0, set inc32 <= cpu_din[2].
REQ-023 SHALL, on a read of reg 2, clear w <= 0 and SHALL NOT pulse cpu_dout_valid.
REQ-024 SHALL, on a write to reg 6 with w=0, set t_hi <= cpu_din[5:0] and w <= 1.
REQ-025 SHALL, on a write to reg 6 with w=1, set v <= {t_hi, cpu_din} and w <= 0.
REQ-026 SHALL, on a write to reg 7, latch the write data and go to WR.
REQ-027 SHALL, in WR, pulse exactly one strobe for one cycle with address v, then set v <= v+inc and go to IDLE:
 - v >= $3F00: pal_wren with pal_wdata = latched data.
 - $2000 <= v < $3F00: vram_wren with vram_addr = v and vram_wdata = latched data.
 - v < $2000 (CHR-ROM space): no strobe.
REQ-028 SHALL, on a read of reg 7 (cycle 0), register cpu_dout with pulse cpu_dout_valid in cycle 1, and go to RD_ISSUE:
 - cpu_dout = pal_rdata if v >= $3F00.
 - cpu_dout = rbuf otherwise.
REQ-029 SHALL, in RD_ISSUE, assert vram_rden for one cycle with vram_addr = v & 14'h2FFF when v >= $2000, then go to RD_CAP.
REQ-030 SHALL, in RD_CAP, set rbuf <= vram_rdata (rbuf <= 8'h00 if v < $2000), set v <= v+inc, and go to IDLE.
REQ-031 SHALL use inc = 32 when inc32=1 and 1 otherwise, with v wrapping modulo 2^14 ($3FFF+1 = $0000; $3FF0+32 = $0010).
REQ-032 SHALL give the $2007 read latency as 1 cycle to cpu_dout_valid and 3 cycles to return to IDLE; a $2007 write SHALL take 2 cycles to IDLE.
REQ-033 SHALL keep vram_wren, vram_rden and pal_wren low in every state not listed above; they SHALL never be high simultaneously.
REQ-034 SHALL ignore writes to reg 2 and reads of regs 0 and 6; reg indices 1, 3, 4 and 5 SHALL have no effect.

Reset
REQ-035 SHALL, while reset_n=0, immediately force state=IDLE, v=0, t_hi=0, w=0, inc32=0, rbuf=0, cpu_dout=0, and all strobes and cpu_dout_valid low.
REQ-036 SHALL abort any sequence when reset is asserted mid-operation: no strobe after reset assertion, and no v increment.

Verification
REQ-037 SHALL be checked with: write $2006 = $21, write $2006 = $08, write $2007 = $5A -> one-cycle vram_wren at addr $2108 with data $5A; v becomes $2109.
REQ-038 SHALL be checked with: VRAM[$2400] = $77, v = $2400, two reads of $2007 -> first cpu_dout = old rbuf, second cpu_dout = $77; v ends at $2402.
REQ-039 SHALL be checked with: write $2000 = $04, v = $23E0, write $2007 -> vram_wren at $23E0; v becomes $2400; from v = $3FF0, v becomes $0010.
REQ-040 SHALL be checked with: v = $3F05, pal_rdata = $1C, read $2007 -> cpu_dout = $1C in cycle 1; vram_rden at $2F05; rbuf loads that byte.
REQ-041 SHALL be checked with: write $2006 = $3F, read $2002, write $2006 = $10 -> t_hi = $10 and w = 1; v unchanged.
REQ-042 SHALL be checked with: cpu_sel pulse during busy -> no effect; reset_n low in RD_ISSUE -> all outputs 0 and v = 0 with no strobe.
